// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the stopwatch controller.
// The defaults assume CLOCK_50: a 10 ms count tick and a 20 ms debounce window.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_t;

    localparam int DEFAULT_TICK_DIV  = 500000;
    localparam int DEFAULT_DB_CYCLES = 1000000;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control bundle between the stopwatch controller (master) and the counter/display (slave).
interface stopwatch_ctrl_if;

    logic cnt_at_max;
    logic cnt_tick;
    logic cnt_clr;
    logic disp_freeze;
    logic run_led;

    modport master (
        input  cnt_at_max,
        output cnt_tick,
        output cnt_clr,
        output disp_freeze,
        output run_led
    );

    modport slave (
        output cnt_at_max,
        input  cnt_tick,
        input  cnt_clr,
        input  disp_freeze,
        input  run_led
    );

endinterface

// File: rtl/stopwatch_ctrl_debounce.sv
// Two-flop synchroniser plus stable-count filter for one active-low push-button.
// Emits a one-cycle press pulse when a new low level is accepted; releases are silent.
module key_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // The new level held for DB_CYCLES samples: accept it.
                level <= sync[1];
                cnt   <= '0;
                press <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer for the stopwatch counter: debounces the two keys,
// divides the clock to the count tick and drives the counter and display controls.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = DEFAULT_TICK_DIV,
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
    input  logic             CLOCK_50,
    input  logic             RST_N,
    input  logic             KEY_SS_N,
    input  logic             KEY_LAP_N,
    stopwatch_ctrl_if.master cnt
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    sw_state_t     state;
    sw_state_t     state_nxt;
    logic [PW-1:0] pre;
    logic          ss_ev;
    logic          lap_ev;
    logic          running;
    logic          tick_pt;
    logic          clr_req;
    logic          rst_done;
    logic          tick_q;
    logic          clr_q;
    logic          freeze_q;
    logic          led_q;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
        .clk   (CLOCK_50),
        .rst_n (RST_N),
        .key_n (KEY_SS_N),
        .press (ss_ev)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .clk   (CLOCK_50),
        .rst_n (RST_N),
        .key_n (KEY_LAP_N),
        .press (lap_ev)
    );

    assign running = (state == RUN) || (state == LAP);
    assign tick_pt = running && (pre == PRE_LAST);

    // NOTE: defaults are assigned first so every path drives every signal and no latch is inferred.
    always_comb begin
        state_nxt = state;
        clr_req   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_ev) state_nxt = RUN;
            end
            RUN, LAP: begin
                // Start/stop outranks lap; reaching 99.99 parks the watch in PAUSE.
                if (ss_ev || (tick_pt && cnt.cnt_at_max)) begin
                    state_nxt = PAUSE;
                end else if (lap_ev) begin
                    state_nxt = (state == RUN) ? LAP : RUN;
                end
            end
            PAUSE: begin
                if (ss_ev) begin
                    state_nxt = RUN;
                end else if (lap_ev) begin
                    state_nxt = IDLE;
                    clr_req   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            pre      <= '0;
            rst_done <= 1'b0;
            tick_q   <= 1'b0;
            clr_q    <= 1'b0;
            freeze_q <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            rst_done <= 1'b1;
            // A fresh start re-phases the prescaler; resuming from PAUSE keeps its phase.
            if (state == IDLE && state_nxt == RUN) begin
                pre <= '0;
            end else if (running) begin
                pre <= tick_pt ? '0 : pre + 1'b1;
            end
            tick_q   <= tick_pt && !cnt.cnt_at_max;
            clr_q    <= !rst_done || clr_req;
            freeze_q <= (state_nxt == LAP);
            led_q    <= (state_nxt == RUN) || (state_nxt == LAP);
        end
    end

    assign cnt.cnt_tick    = tick_q;
    assign cnt.cnt_clr     = clr_q;
    assign cnt.disp_freeze = freeze_q;
    assign cnt.run_led     = led_q;

endmodule
